// File: rtl/irq_resp_pkg.sv
// irq_resp shared types: FSM encoding, ack address default,
// and the 4-line priority encoder used by both bus sides.
package irq_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAKE,
    ACK,
    WAITDROP,
    ISR,
    RET
  } state_t;

  localparam logic [1:0] IACK_ADDR_DEF = 2'b00;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } prio_t;

  // Lowest set bit wins; overlapping matches are expected.
  function automatic prio_t prio_enc4(input logic [3:0] req);
    prio_t r;
    r.valid = |req;
    r.idx   = 2'd0;
    priority case (1'b1)
      req[0]:  r.idx = 2'd0;
      req[1]:  r.idx = 2'd1;
      req[2]:  r.idx = 2'd2;
      req[3]:  r.idx = 2'd3;
      default: r.idx = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/irq_resp_prio_enc.sv
// 4->2 priority encoder with valid; masked lines
// (mask bit = 1) never win.
module irq_prio_enc
  import irq_resp_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] mask,
  output logic [1:0] idx,
  output logic       valid
);

  prio_t res;

  always_comb begin
    res   = prio_enc4(req & ~mask);
    idx   = res.idx;
    valid = res.valid;
  end

endmodule

// File: rtl/irq_resp.sv
// CPU-side interrupt responder: take, redirect, ack, ISR tracking.
// Optional line masking is built with IRQ_RESP_MASK_EN defined.
module irq_resp
  import irq_resp_pkg::*;
#(
  parameter logic [1:0] IACK_ADDR   = IACK_ADDR_DEF,
  parameter int         ACK_TIMEOUT = 16,
  parameter int         NUM_IRQ     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        Eaddr,
  input  logic [31:0]        pc_next,
  input  logic               retire,
  input  logic               eret,
  input  logic               ie,
  input  logic               bus_gnt,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic               flush,
  output logic [1:0]         A,
  output logic               WE,
  output logic [31:0]        WD,
  output logic [31:0]        epc,
  output logic [1:0]         cause,
  output logic               in_isr,
  output logic               ack_err
`ifdef IRQ_RESP_MASK_EN
  ,
  input  logic               mask_we,
  input  logic [3:0]         mask_wd
`endif
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [3:0]    ONE      = 4'b0001;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [3:0]    mask;
  logic [1:0]    pe_idx;
  logic          pe_valid;
  logic          take;
  logic          timeout;

`ifdef IRQ_RESP_MASK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wd;
    end
  end
`else
  assign mask = '0;
`endif

  irq_prio_enc u_prio (
    .req   (irq),
    .mask  (mask),
    .idx   (pe_idx),
    .valid (pe_valid)
  );

  assign take    = (state == IDLE) && ie && retire && pe_valid;
  assign timeout = (cnt == CNT_LAST);

  always_comb begin
    state_d     = state;
    pc_redirect = 1'b0;
    flush       = 1'b0;
    pc_target   = '0;
    WE          = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) state_d = TAKE;
      end
      TAKE: begin
        pc_redirect = 1'b1;
        flush       = 1'b1;
        pc_target   = Eaddr;
        state_d     = ACK;
      end
      ACK: begin
        if (bus_gnt) begin
          WE      = 1'b1;
          state_d = WAITDROP;
        end
      end
      WAITDROP: begin
        if (!irq[cause] || timeout) state_d = ISR;
      end
      ISR: begin
        if (eret) state_d = RET;
      end
      RET: begin
        pc_redirect = 1'b1;
        flush       = 1'b1;
        pc_target   = epc;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      epc     <= '0;
      cause   <= '0;
      in_isr  <= 1'b0;
      ack_err <= 1'b0;
      A       <= '0;
      WD      <= '0;
      cnt     <= '0;
    end else begin
      state <= state_d;
      if (take) begin
        epc   <= pc_next;
        cause <= pe_idx;
      end
      // A/WD are loaded ahead of ACK and then held.
      if (state == TAKE) begin
        in_isr <= 1'b1;
        A      <= IACK_ADDR;
        WD     <= {28'b0, ONE << cause};
      end
      if (state == RET) in_isr <= 1'b0;
      if (state == ACK) begin
        cnt <= '0;
      end else if (state == WAITDROP && irq[cause]) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (timeout) ack_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_irq_resp.sv
// Self-checking bench for irq_resp: vector table, hand-written
// corner sequences and randomized transactions vs a model.
module tb_irq_resp;

  localparam logic [1:0] IACK = 2'b00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq = '0;
  logic [31:0] Eaddr = '0;
  logic [31:0] pc_next = '0;
  logic        retire = 1'b0;
  logic        eret = 1'b0;
  logic        ie = 1'b1;
  logic        bus_gnt = 1'b0;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        flush;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        in_isr;
  logic        ack_err;
`ifdef IRQ_RESP_MASK_EN
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wd = '0;
`endif

  int   checks = 0;
  int   failures = 0;
  logic err_exp = 1'b0;
  logic [3:0] mask_model = '0;

  irq_resp dut (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .Eaddr       (Eaddr),
    .pc_next     (pc_next),
    .retire      (retire),
    .eret        (eret),
    .ie          (ie),
    .bus_gnt     (bus_gnt),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .flush       (flush),
    .A           (A),
    .WE          (WE),
    .WD          (WD),
    .epc         (epc),
    .cause       (cause),
    .in_isr      (in_isr),
    .ack_err     (ack_err)
`ifdef IRQ_RESP_MASK_EN
    ,
    .mask_we     (mask_we),
    .mask_wd     (mask_wd)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irq;
    logic        ie;
    logic        retire;
    logic        eret;
    int          stalls;
    int          hold;
    logic [31:0] ea;
    logic [31:0] pc;
    logic        take;
    logic [1:0]  cause;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  // One full interrupt: take, ack (with stalls), drop/timeout,
  // ISR with noise, eret and return to IDLE.
  task automatic txn(input logic [3:0] iv, input logic [31:0] ea,
                     input logic [31:0] pc, input int stalls,
                     input int hold, input int isr_len,
                     input logic [1:0] ec, input logic [31:0] ewd,
                     input string tag);
    int w;
    irq = iv; Eaddr = ea; pc_next = pc;
    retire = 1'b1; ie = 1'b1; bus_gnt = 1'b0; eret = 1'b0;
    step();
    chk({tag, "_redir"}, 32'(pc_redirect), 32'd1);
    chk({tag, "_flush"}, 32'(flush), 32'd1);
    chk({tag, "_target"}, pc_target, ea);
    chk({tag, "_epc"}, epc, pc);
    chk({tag, "_cause"}, 32'(cause), 32'(ec));
    retire = 1'b0; Eaddr = $urandom; pc_next = $urandom;
    step();
    chk({tag, "_in_isr"}, 32'(in_isr), 32'd1);
    chk({tag, "_ack_redir"}, 32'(pc_redirect), 32'd0);
    for (int s = 0; s < stalls; s++) begin
      chk({tag, "_stall_we"}, 32'(WE), 32'd0);
      step();
    end
    bus_gnt = 1'b1;
    #1;
    chk({tag, "_we"}, 32'(WE), 32'd1);
    chk({tag, "_a"}, 32'(A), 32'(IACK));
    chk({tag, "_wd"}, WD, ewd);
    if (hold == 0) irq = '0;
    step();
    bus_gnt = 1'b0;
    chk({tag, "_we_once"}, 32'(WE), 32'd0);
    w = (hold >= 16) ? 16 : hold + 1;
    for (int k = 0; k < w; k++) begin
      irq = (k < hold) ? iv : 4'b0000;
      if (k == w - 1)
        chk({tag, "_err_early"}, 32'(ack_err), 32'(err_exp));
      step();
    end
    err_exp = err_exp | (hold >= 16);
    chk({tag, "_ack_err"}, 32'(ack_err), 32'(err_exp));
    for (int i = 0; i < isr_len; i++) begin
      irq = $urandom; retire = $urandom; pc_next = $urandom;
      step();
      chk({tag, "_isr_noredir"}, 32'(pc_redirect), 32'd0);
    end
    eret = 1'b1; retire = 1'b1;
    #1;
    chk({tag, "_isr_hold"}, 32'(pc_redirect), 32'd0);
    step();
    chk({tag, "_ret_redir"}, 32'(pc_redirect), 32'd1);
    chk({tag, "_ret_flush"}, 32'(flush), 32'd1);
    chk({tag, "_ret_target"}, pc_target, pc);
    eret = 1'b0; irq = '0; retire = 1'b0;
    step();
    chk({tag, "_idle_isr"}, 32'(in_isr), 32'd0);
    chk({tag, "_idle_redir"}, 32'(pc_redirect), 32'd0);
  endtask

  task automatic no_take(input vec_t v, input string tag);
    irq = v.irq; ie = v.ie; retire = v.retire; eret = v.eret;
    step();
    chk({tag, "_noredir"}, 32'(pc_redirect), 32'd0);
    chk({tag, "_noisr"}, 32'(in_isr), 32'd0);
    irq = '0; ie = 1'b1; retire = 1'b0; eret = 1'b0;
    step();
    chk({tag, "_noredir2"}, 32'(pc_redirect), 32'd0);
  endtask

  initial begin
    vecs.push_back('{4'b0100, 1, 1, 0, 0, 0, 32'h0000_0180,
                     32'h0040_0010, 1, 2'd2, 32'h4});
    vecs.push_back('{4'b1010, 1, 1, 0, 0, 1, 32'h0000_0200,
                     32'h0040_0100, 1, 2'd1, 32'h2});
    vecs.push_back('{4'b0001, 1, 1, 0, 3, 2, 32'h0000_0300,
                     32'h0040_0204, 1, 2'd0, 32'h1});
    vecs.push_back('{4'b0001, 0, 1, 0, 0, 0, 32'h0,
                     32'h0, 0, 2'd0, 32'h0});
    vecs.push_back('{4'b0001, 1, 0, 0, 0, 0, 32'h0,
                     32'h0, 0, 2'd0, 32'h0});
    vecs.push_back('{4'b0000, 1, 1, 1, 0, 0, 32'h0,
                     32'h0, 0, 2'd0, 32'h0});
    vecs.push_back('{4'b1000, 1, 1, 0, 1, 15, 32'h0000_0400,
                     32'h0040_0300, 1, 2'd3, 32'h8});
    vecs.push_back('{4'b0001, 1, 1, 0, 0, 16, 32'h0000_0500,
                     32'h0040_0400, 1, 2'd0, 32'h1});
    vecs.push_back('{4'b1100, 1, 1, 0, 2, 3, 32'h0000_0600,
                     32'h0040_0500, 1, 2'd2, 32'h4});

    #3;
    chk("rst_redir", 32'(pc_redirect), 32'd0);
    chk("rst_we", 32'(WE), 32'd0);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_wd", WD, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_in_isr", 32'(in_isr), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      if (vecs[i].take)
        txn(vecs[i].irq, vecs[i].ea, vecs[i].pc, vecs[i].stalls,
            vecs[i].hold, 2, vecs[i].cause, vecs[i].wd,
            $sformatf("vec%0d", i));
      else
        no_take(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: a pending line is taken right after RET.
    txn(4'b0010, 32'h0000_0700, 32'h0040_0600, 0, 0, 0,
        2'd1, 32'h2, "b2b_a");
    txn(4'b0010, 32'h0000_0704, 32'h0040_0604, 0, 0, 0,
        2'd1, 32'h2, "b2b_b");

`ifdef IRQ_RESP_MASK_EN
    mask_we = 1'b1; mask_wd = 4'b0001; mask_model = 4'b0001;
    step();
    mask_we = 1'b0;
    no_take('{4'b0001, 1, 1, 0, 0, 0, 32'h0, 32'h0, 0,
              2'd0, 32'h0}, "mask_off");
    txn(4'b0011, 32'h0000_0800, 32'h0040_0700, 0, 0, 1,
        2'd1, 32'h2, "mask_prio");
    mask_we = 1'b1; mask_wd = 4'b0000; mask_model = 4'b0000;
    step();
    mask_we = 1'b0;
`endif

    for (int n = 0; n < 25; n++) begin
      logic [3:0]  iv;
      logic [31:0] ea, pc;
      int          c, hold;
      iv   = 4'($urandom_range(1, 15));
      iv   = iv | 4'b1000;
      ea   = $urandom;
      pc   = $urandom;
      c    = lowest(iv & ~mask_model);
      hold = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
      txn(iv, ea, pc, $urandom_range(0, 3), hold,
          $urandom_range(0, 4), 2'(c), 32'd1 << c,
          $sformatf("rnd%0d", n));
    end

    // Asynchronous reset while the handler is running.
    irq = 4'b0001; retire = 1'b1; pc_next = 32'h0040_0abc;
    Eaddr = 32'h180;
    step();
    retire = 1'b0; bus_gnt = 1'b1;
    step();
    irq = '0;
    step();
    bus_gnt = 1'b0;
    step();
    chk("mid_isr", 32'(in_isr), 32'd1);
    chk("mid_epc", epc, 32'h0040_0abc);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_in_isr", 32'(in_isr), 32'd0);
    chk("arst_epc", epc, 32'd0);
    chk("arst_we", 32'(WE), 32'd0);
    chk("arst_ack_err", 32'(ack_err), 32'd0);
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    txn(4'b0100, 32'h0000_0900, 32'h0040_0800, 1, 1, 1,
        2'd2, 32'h4, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_resp.md
Name: irq_resp

Overview:
- CPU-side responder for the memory-mapped interrupt controller.
- Watches irq[3:0] and the handler vector, and takes the interrupt at an instruction boundary: saves EPC, redirects the PC to the handler, and flushes the pipeline.
- Issues the acknowledge write on the controller bus port, then tracks ISR occupancy until eret returns to EPC.
- Sits between the MIPS core fetch/PC logic and the controller's A/WE/WD inputs.

Parameters:
- IACK_ADDR, 2'b00: controller address whose write strobes the acknowledge register.
- ACK_TIMEOUT, 16: cycles allowed for the acknowledged irq line to drop before ack_err is set.
- NUM_IRQ, 4: interrupt line count; fixed at 4 in this revision.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- irq  in  4  interrupt request lines; bit 0 has highest priority.
- Eaddr  in  32  handler vector from the controller.
- pc_next  in  32  address of the next instruction to execute.
- retire  in  1  an instruction boundary is valid this cycle.
- eret  in  1  return-from-interrupt decoded and retiring.
- ie  in  1  global interrupt enable from the core status bit.
- bus_gnt  in  1  core data bus is free for the ack write this cycle.
- pc_redirect  out  1  one-cycle pulse: load pc_target into PC.
- pc_target  out  32  redirect address.
- flush  out  1  pipeline flush; coincident with pc_redirect.
- A  out  2  controller address.
- WE  out  1  controller write enable.
- WD  out  32  controller write data.
- epc  out  32  saved return address.
- cause  out  2  index of the taken line.
- in_isr  out  1  handler is executing.
- ack_err  out  1  sticky: acknowledged line failed to drop within ACK_TIMEOUT.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, including epc, cause, in_isr, ack_err, WE, A, WD, and the timeout counter.
- States: IDLE, TAKE, ACK, WAITDROP, ISR, RET.
- IDLE:
  - Take condition: ie=1, retire=1 and irq!=0.
  - On take, in the same edge: epc<=pc_next; cause<=priority encode of irq (lowest set bit index); go to TAKE.
  - Otherwise stay in IDLE.
- TAKE (1 cycle):
  - pc_redirect=1, flush=1, pc_target=Eaddr as sampled this cycle; in_isr<=1.
  - Go to ACK.
- ACK:
  - Drive A=IACK_ADDR and WD={28'b0, onehot(cause)}.
  - WE=1 only when bus_gnt=1. Hold in ACK with WE=0 while bus_gnt=0.
  - After a cycle with WE=1, go to WAITDROP and clear the counter.
- WAITDROP:
  - If irq[cause]=0, go to ISR.
  - Otherwise increment the counter. At count == ACK_TIMEOUT-1, set ack_err and go to ISR anyway.
  - The counter saturates and never wraps.
- ISR:
  - in_isr=1; no new interrupt is taken (no nesting).
  - On eret=1, go to RET.
  - irq activity is ignored.
- RET (1 cycle):
  - pc_redirect=1, flush=1, pc_target=epc; in_isr<=0.
  - Go to IDLE.
  - A new interrupt can be taken at the first retire cycle after RET, giving minimum 1 cycle between ISRs.
- Outside ACK: WE=0; A and WD hold their last values.
- eret while not in ISR: ignored.
- irq dropping during TAKE or ACK: the ack is still issued, and cause is not re-evaluated.
- Eaddr change after TAKE: no effect.
- ack_err: cleared only by reset.
- Latency: irq sampled at a retire cycle → redirect on the next cycle → ack WE one cycle later at the earliest.

Optional Feature:
- Macro: IRQ_RESP_MASK_EN.
- Defined:
  - Adds ports mask_we (in, 1) and mask_wd (in, 4).
  - 4-bit mask register, reset 4'b0000 (all enabled); loaded from mask_wd when mask_we=1.
  - Masked lines (mask bit=1) are excluded from both the take condition and the priority encoder.
  - A mask write during ISR takes effect at the next IDLE evaluation.
- Undefined: ports and register absent; all lines enabled.

Decomposition:
- Shared package irq_resp_pkg holds:
  - the state encoding typedef (6 states, 3 bits);
  - IACK_ADDR default;
  - a priority-encode function mapping 4-bit to index plus valid.
- One sub-module is natural: irq_prio_enc (4→2 priority encoder with valid, optional mask input), reused by the controller side.

Test Plan:
- Single irq: irq=4'b0100, Eaddr=32'h0000_0180, pc_next=32'h0040_0010, retire=1 → next cycle pc_redirect=1, pc_target=32'h180, flush=1; then WE=1, A=IACK_ADDR, WD=32'h4; cause=2; epc=32'h0040_0010; drop irq → ISR, in_isr=1; eret → pc_target=32'h0040_0010, in_isr=0.
- Priority: irq=4'b1010 → cause=1, WD=32'h2.
- Bus stall: bus_gnt=0 for 3 cycles in ACK → WE=0 for those cycles, WE=1 exactly once on the 4th cycle.
- Timeout: irq held at 4'b0001 after ack → ack_err=1 after 16 cycles in WAITDROP; FSM reaches ISR.
- Gating: ie=0 or retire=0 with irq=4'b0001 → no redirect. irq asserted during ISR → no take until after RET.
- Reset mid-ISR: assert rst=0 while in_isr=1 → in_isr, epc, WE and ack_err go to 0 immediately without waiting for a clk edge. With IRQ_RESP_MASK_EN, mask=4'b0001 and irq=4'b0011 → cause=1.
